// File: rtl/ysyx_041514_lsu_ctrl_pkg.sv
// Shared definitions for the LSU memory-access controller: FSM states, size
// bit positions, strobe masks and size normalisation.
package ysyx_041514_lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    ysyx_041514_LSU_IDLE = 2'd0,
    ysyx_041514_LSU_REQ  = 2'd1,
    ysyx_041514_LSU_WAIT = 2'd2
  } lsu_state_e;

  localparam int LSU_SZ_B = 0;
  localparam int LSU_SZ_H = 1;
  localparam int LSU_SZ_W = 2;
  localparam int LSU_SZ_D = 3;

  localparam logic [7:0] LSU_STRB_B = 8'h01;
  localparam logic [7:0] LSU_STRB_H = 8'h03;
  localparam logic [7:0] LSU_STRB_W = 8'h0F;
  localparam logic [7:0] LSU_STRB_D = 8'hFF;

  // Largest set size bit wins; an all-zero size collapses to a byte access.
  function automatic logic [3:0] lsu_size_norm(input logic [3:0] s);
    if (s[LSU_SZ_D])      return 4'b1000;
    else if (s[LSU_SZ_W]) return 4'b0100;
    else if (s[LSU_SZ_H]) return 4'b0010;
    else                  return 4'b0001;
  endfunction

  function automatic logic [7:0] lsu_size_mask(input logic [3:0] s);
    if (s[LSU_SZ_D])      return LSU_STRB_D;
    else if (s[LSU_SZ_W]) return LSU_STRB_W;
    else if (s[LSU_SZ_H]) return LSU_STRB_H;
    else                  return LSU_STRB_B;
  endfunction

endpackage

// File: rtl/ysyx_041514_lsu_ctrl_align.sv
// Byte-lane alignment: store strobe/data shift into the doubleword and load
// data shift plus sign/zero extension. Purely combinational.
module ysyx_041514_lsu_align
  import ysyx_041514_lsu_ctrl_pkg::*;
(
  input  logic [3:0]  i_size,
  input  logic [2:0]  i_off,
  input  logic        i_signed,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [5:0]  w_shamt;
  logic [63:0] w_rdata_sh;

  function automatic logic [63:0] load_extend(input logic [63:0] d,
                                              input logic [3:0]  sz,
                                              input logic        sgn);
    if (sz[LSU_SZ_D])      return d;
    else if (sz[LSU_SZ_W]) return {{32{sgn & d[31]}}, d[31:0]};
    else if (sz[LSU_SZ_H]) return {{48{sgn & d[15]}}, d[15:0]};
    else                   return {{56{sgn & d[7]}},  d[7:0]};
  endfunction

  assign w_shamt    = {i_off, 3'b000};
  // Lanes shifted past byte 7 fall off the 8-bit strobe.
  assign o_wstrb    = lsu_size_mask(i_size) << i_off;
  assign o_wdata    = i_wdata << w_shamt;
  assign w_rdata_sh = i_rdata >> w_shamt;
  assign o_rdata    = load_extend(w_rdata_sh, i_size, i_signed);

endmodule

// File: rtl/ysyx_041514_lsu_ctrl.sv
// MEM-stage load/store controller: single-outstanding 64-bit bus handshake.
// Optional misaligned-access fault: define YSYX_041514_LSU_MISALIGN_CHECK_EN.
module ysyx_041514_lsu_ctrl
  import ysyx_041514_lsu_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ls_valid_i,
  output logic                  ls_ready_o,
  input  logic                  ls_type_i,
  input  logic                  ls_signed_i,
  input  logic [3:0]            ls_size_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic                  mem_req_wen_o,
  output logic [DATA_WIDTH-1:0] mem_req_wdata_o,
  output logic [7:0]            mem_req_wstrb_o,
  input  logic                  mem_resp_valid_i,
  output logic                  mem_resp_ready_o,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata_i,
  output logic                  ls_done_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  ls_misalign_o
);

  lsu_state_e            r_state;
  logic                  r_type;
  logic                  r_signed;
  logic [3:0]            r_size;
  logic [2:0]            r_off;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_done;
  logic                  r_misalign;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [3:0]            w_size_in;
  logic [7:0]            w_strb;
  logic [DATA_WIDTH-1:0] w_wdata_sh;
  logic [DATA_WIDTH-1:0] w_rdata_ext;
  logic                  w_misalign;

  assign w_size_in = lsu_size_norm(ls_size_i);

`ifdef YSYX_041514_LSU_MISALIGN_CHECK_EN
  assign w_misalign = (w_size_in[LSU_SZ_H] & ls_addr_i[0])
                    | (w_size_in[LSU_SZ_W] & (|ls_addr_i[1:0]))
                    | (w_size_in[LSU_SZ_D] & (|ls_addr_i[2:0]));
`else
  assign w_misalign = 1'b0;
`endif

  ysyx_041514_lsu_align u_align (
    .i_size   (r_size),
    .i_off    (r_off),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .i_rdata  (mem_resp_rdata_i),
    .o_wstrb  (w_strb),
    .o_wdata  (w_wdata_sh),
    .o_rdata  (w_rdata_ext)
  );

  assign ls_ready_o       = (r_state == ysyx_041514_LSU_IDLE);
  assign mem_req_valid_o  = (r_state == ysyx_041514_LSU_REQ);
  assign mem_resp_ready_o = (r_state == ysyx_041514_LSU_WAIT);
  assign mem_req_addr_o   = r_addr;
  assign mem_req_wdata_o  = w_wdata_sh;
  assign mem_req_wen_o    = mem_req_valid_o & r_type;
  assign mem_req_wstrb_o  = mem_req_valid_o ? w_strb : 8'h00;
  assign ls_done_o        = r_done;
  assign ls_rdata_o       = r_rdata;
  assign ls_misalign_o    = r_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ysyx_041514_LSU_IDLE;
      r_type     <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        ysyx_041514_LSU_IDLE: begin
          if (ls_valid_i) begin
            r_type   <= ls_type_i;
            r_signed <= ls_signed_i;
            r_size   <= w_size_in;
            r_off    <= ls_addr_i[2:0];
            r_wdata  <= ls_wdata_i;
            r_addr   <= {ls_addr_i[ADDR_WIDTH-1:3], 3'b000};
            // A faulting access completes immediately without touching the bus.
            if (w_misalign) begin
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
              r_rdata    <= '0;
            end else begin
              r_state <= ysyx_041514_LSU_REQ;
            end
          end
        end
        ysyx_041514_LSU_REQ: begin
          if (mem_req_ready_i) r_state <= ysyx_041514_LSU_WAIT;
        end
        ysyx_041514_LSU_WAIT: begin
          if (mem_resp_valid_i) begin
            r_state <= ysyx_041514_LSU_IDLE;
            r_done  <= 1'b1;
            r_rdata <= r_type ? '0 : w_rdata_ext;
          end
        end
        default: r_state <= ysyx_041514_LSU_IDLE;
      endcase
    end
  end

endmodule
